// File: rtl/regfile_wb.sv
// ============================================================================
// Module   : regfile_wb
// Brief    : Y86-64 SEQ register file with decode source/destination select
//            and valE/valM writeback. Optional macro STACK_INIT_EN resets
//            %rsp to STACK_BASE instead of zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb #(
  parameter int                DATA_W     = 64,
  parameter logic [DATA_W-1:0] STACK_BASE = 64'h0000_0000_0000_0200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  input  logic              Cnd,
  input  logic              wb_en,
  output logic [3:0]        srcA,
  output logic [3:0]        srcB,
  output logic [3:0]        dstE,
  output logic [3:0]        dstM,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [DATA_W-1:0] rsp_q
);

  localparam logic [3:0] c_rnone   = 4'hF;
  localparam logic [3:0] c_rsp     = 4'h4;
  localparam logic [3:0] c_rrmovq  = 4'h2;
  localparam logic [3:0] c_irmovq  = 4'h3;
  localparam logic [3:0] c_rmmovq  = 4'h4;
  localparam logic [3:0] c_mrmovq  = 4'h5;
  localparam logic [3:0] c_opq     = 4'h6;
  localparam logic [3:0] c_call    = 4'h8;
  localparam logic [3:0] c_ret     = 4'h9;
  localparam logic [3:0] c_pushq   = 4'hA;
  localparam logic [3:0] c_popq    = 4'hB;

`ifdef STACK_INIT_EN
  localparam bit c_stack_init = 1'b1;
`else
  localparam bit c_stack_init = 1'b0;
`endif

  // ifun only travels with the instruction for tracing
  logic w_unused_ifun;
  assign w_unused_ifun = &{1'b0, ifun};

  // Entry 15 is the hard-wired "no register" slot that always reads zero
  logic [DATA_W-1:0] w_rf [0:15];

  always_comb begin
    srcA = c_rnone;
    srcB = c_rnone;
    dstE = c_rnone;
    dstM = c_rnone;
    case (icode)
      c_rrmovq: begin
        srcA = rA;
        dstE = Cnd ? rB : c_rnone;
      end
      c_irmovq: begin
        dstE = rB;
      end
      c_rmmovq: begin
        srcA = rA;
        srcB = rB;
      end
      c_mrmovq: begin
        srcB = rB;
        dstM = rA;
      end
      c_opq: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      c_call: begin
        srcB = c_rsp;
        dstE = c_rsp;
      end
      c_ret: begin
        srcA = c_rsp;
        srcB = c_rsp;
        dstE = c_rsp;
      end
      c_pushq: begin
        srcA = rA;
        srcB = c_rsp;
        dstE = c_rsp;
      end
      c_popq: begin
        srcA = c_rsp;
        srcB = c_rsp;
        dstE = c_rsp;
        dstM = rA;
      end
      default: begin
        srcA = c_rnone;
        srcB = c_rnone;
        dstE = c_rnone;
        dstM = c_rnone;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_reg
      localparam logic [DATA_W-1:0] c_rst_val =
        (c_stack_init && (gi == 4)) ? STACK_BASE : '0;
      logic [DATA_W-1:0] r_q;

      // valM takes priority so popq %rsp commits the popped value
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_q <= c_rst_val;
        end else if (wb_en) begin
          if (dstM == 4'(gi)) begin
            r_q <= valM;
          end else if (dstE == 4'(gi)) begin
            r_q <= valE;
          end
        end
      end

      assign w_rf[gi] = r_q;
    end
  endgenerate

  assign w_rf[15] = '0;

  assign valA  = w_rf[srcA];
  assign valB  = w_rf[srcB];
  assign rsp_q = w_rf[4];

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb.sv
// ============================================================================
// Module   : tb_regfile_wb
// Brief    : Directed, table-driven self-checking bench for regfile_wb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb;

  logic        clk;
  logic        rst;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valE, valM;
  logic        Cnd, wb_en;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB, rsp_q;

  int checks;
  int errors;

`ifdef STACK_INIT_EN
  localparam logic [63:0] RSP0 = 64'h200;
`else
  localparam logic [63:0] RSP0 = 64'h0;
`endif

  regfile_wb #(.DATA_W(64)) dut (
    .clk(clk), .rst(rst), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valE(valE), .valM(valM), .Cnd(Cnd), .wb_en(wb_en),
    .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
    .valA(valA), .valB(valB), .rsp_q(rsp_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] vale, valm;
    logic        cnd, wb;
    logic [3:0]  sa, sb, de, dm;
    logic [63:0] va, vb, rsp;
  } vec_t;

  vec_t vecs [0:18];

  function automatic vec_t mk(
    input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
    input logic [3:0] rb, input logic [63:0] ve, input logic [63:0] vm,
    input logic c, input logic w, input logic [3:0] sa, input logic [3:0] sb,
    input logic [3:0] de, input logic [3:0] dm, input logic [63:0] va,
    input logic [63:0] vb, input logic [63:0] rsp);
    vec_t v;
    v.icode = ic; v.ifun = fn; v.ra = ra; v.rb = rb; v.vale = ve; v.valm = vm;
    v.cnd = c; v.wb = w; v.sa = sa; v.sb = sb; v.de = de; v.dm = dm;
    v.va = va; v.vb = vb; v.rsp = rsp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] ve, input logic [63:0] vm, input logic c,
                       input logic w);
    icode = ic; ifun = 4'h0; rA = ra; rB = rb; valE = ve; valM = vm; Cnd = c; wb_en = w;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 1'b0, 1'b0);

    //           icode ifun rA    rB    valE       valM      Cnd wb   srcA  srcB  dstE  dstM  valA       valB       rsp_q
    vecs[0]  = mk(4'h3, 4'h0, 4'hF, 4'h2, 64'h7,     64'h0,    0, 1, 4'hF, 4'hF, 4'h2, 4'hF, 64'h0,     64'h0,     RSP0);
    vecs[1]  = mk(4'h2, 4'h0, 4'h2, 4'h3, 64'h7,     64'h0,    1, 1, 4'h2, 4'hF, 4'h3, 4'hF, 64'h7,     64'h0,     RSP0);
    vecs[2]  = mk(4'h2, 4'h1, 4'h0, 4'h5, 64'h9,     64'h0,    0, 1, 4'h0, 4'hF, 4'hF, 4'hF, 64'h0,     64'h0,     RSP0);
    vecs[3]  = mk(4'h6, 4'h0, 4'h5, 4'h3, 64'h11,    64'h0,    0, 1, 4'h5, 4'h3, 4'h3, 4'hF, 64'h0,     64'h7,     RSP0);
    vecs[4]  = mk(4'h2, 4'h1, 4'h0, 4'h5, 64'h9,     64'h0,    1, 1, 4'h0, 4'hF, 4'h5, 4'hF, 64'h0,     64'h0,     RSP0);
    vecs[5]  = mk(4'h5, 4'h0, 4'h7, 4'h5, 64'h30,    64'hAB,   0, 1, 4'hF, 4'h5, 4'hF, 4'h7, 64'h0,     64'h9,     RSP0);
    vecs[6]  = mk(4'h3, 4'h0, 4'hF, 4'h4, 64'h200,   64'h0,    0, 1, 4'hF, 4'hF, 4'h4, 4'hF, 64'h0,     64'h0,     RSP0);
    vecs[7]  = mk(4'hA, 4'h0, 4'h1, 4'hF, 64'h1F8,   64'h0,    0, 1, 4'h1, 4'h4, 4'h4, 4'hF, 64'h0,     64'h200,   64'h200);
    vecs[8]  = mk(4'hB, 4'h0, 4'h4, 4'hF, 64'h208,   64'h55,   0, 1, 4'h4, 4'h4, 4'h4, 4'h4, 64'h1F8,   64'h1F8,   64'h1F8);
    vecs[9]  = mk(4'h4, 4'h0, 4'h7, 4'h4, 64'h99,    64'h0,    0, 1, 4'h7, 4'h4, 4'hF, 4'hF, 64'hAB,    64'h55,    64'h55);
    vecs[10] = mk(4'h6, 4'h0, 4'h6, 4'h6, 64'h3,     64'h0,    0, 0, 4'h6, 4'h6, 4'h6, 4'hF, 64'h0,     64'h0,     64'h55);
    vecs[11] = mk(4'h6, 4'h0, 4'h6, 4'h7, 64'h44,    64'h0,    0, 1, 4'h6, 4'h7, 4'h7, 4'hF, 64'h0,     64'hAB,    64'h55);
    vecs[12] = mk(4'h8, 4'h0, 4'hF, 4'hF, 64'h4D,    64'h0,    0, 1, 4'hF, 4'h4, 4'h4, 4'hF, 64'h0,     64'h55,    64'h55);
    vecs[13] = mk(4'h9, 4'h0, 4'hF, 4'hF, 64'h55,    64'h123,  0, 1, 4'h4, 4'h4, 4'h4, 4'hF, 64'h4D,    64'h4D,    64'h4D);
    vecs[14] = mk(4'h7, 4'h0, 4'h1, 4'h2, 64'h66,    64'h66,   1, 1, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,     64'h0,     64'h55);
    vecs[15] = mk(4'hC, 4'h0, 4'h2, 4'h3, 64'h1,     64'h2,    1, 1, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,     64'h0,     64'h55);
    vecs[16] = mk(4'h4, 4'h0, 4'h7, 4'h2, 64'h0,     64'h0,    0, 1, 4'h7, 4'h2, 4'hF, 4'hF, 64'h44,    64'h7,     64'h55);
    vecs[17] = mk(4'h2, 4'h0, 4'h3, 4'hF, 64'h77,    64'h0,    1, 1, 4'h3, 4'hF, 4'hF, 4'hF, 64'h11,    64'h0,     64'h55);
    vecs[18] = mk(4'h4, 4'h0, 4'h3, 4'h5, 64'h0,     64'h0,    0, 1, 4'h3, 4'h5, 4'hF, 4'hF, 64'h11,    64'h9,     64'h55);

    // Reset contents across every read index while rst is held
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(4'h4, 4'(i), 4'(i), 64'h0, 64'h0, 1'b0, 1'b1);
      #1;
      chk($sformatf("rst_valA_r%0d", i), valA, (i == 4) ? RSP0 : 64'h0);
      chk($sformatf("rst_valB_r%0d", i), valB, (i == 4) ? RSP0 : 64'h0);
    end
    chk("rst_rsp_q", rsp_q, RSP0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      icode = vecs[i].icode; ifun = vecs[i].ifun; rA = vecs[i].ra; rB = vecs[i].rb;
      valE = vecs[i].vale; valM = vecs[i].valm; Cnd = vecs[i].cnd; wb_en = vecs[i].wb;
      #1;
      chk($sformatf("v%0d_srcA", i), {60'h0, srcA}, {60'h0, vecs[i].sa});
      chk($sformatf("v%0d_srcB", i), {60'h0, srcB}, {60'h0, vecs[i].sb});
      chk($sformatf("v%0d_dstE", i), {60'h0, dstE}, {60'h0, vecs[i].de});
      chk($sformatf("v%0d_dstM", i), {60'h0, dstM}, {60'h0, vecs[i].dm});
      chk($sformatf("v%0d_valA", i), valA, vecs[i].va);
      chk($sformatf("v%0d_valB", i), valB, vecs[i].vb);
      chk($sformatf("v%0d_rsp_q", i), rsp_q, vecs[i].rsp);
    end

    // Mid-cycle async reset with a write pending on R[2]
    @(negedge clk);
    drive(4'h3, 4'hF, 4'h2, 64'h5A, 64'h0, 1'b0, 1'b1);
    #1;
    chk("pre_rst_rsp_q", rsp_q, 64'h55);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_rsp_q", rsp_q, RSP0);
    drive(4'h4, 4'h2, 4'h7, 64'h0, 64'h0, 1'b0, 1'b1);
    #1;
    chk("async_rst_valA_r2", valA, 64'h0);
    chk("async_rst_valB_r7", valB, 64'h0);
    drive(4'h3, 4'hF, 4'h2, 64'h5A, 64'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(4'h4, 4'h2, 4'h3, 64'h0, 64'h0, 1'b0, 1'b1);
    #1;
    chk("post_rst_valA_r2", valA, 64'h0);
    chk("post_rst_valB_r3", valB, 64'h0);

    // First write after reset lands and is visible the next cycle
    @(negedge clk);
    drive(4'h3, 4'hF, 4'h2, 64'h5A, 64'h0, 1'b0, 1'b1);
    @(negedge clk);
    drive(4'h2, 4'h2, 4'hF, 64'h0, 64'h0, 1'b0, 1'b1);
    #1;
    chk("post_rst_write_r2", valA, 64'h5A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Y86-64 SEQ register file plus decode/writeback source and destination selection.
- Produces valA/valB for the execute stage.
- Consumes the execute result (valE, Cnd) and the memory result (valM), committing them to the 15 program registers on the clock edge.
- Sits between fetch and execute on the read side, and after execute/memory on the write side.

Parameters:
- DATA_W, 64, register and data width in bits.
- STACK_BASE, 64'h0000_0000_0000_0200, reset value of %rsp (register 4) when STACK_INIT_EN is defined.

Ports:
- clk  in  1  system clock; all register writes occur on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- icode  in  4  current instruction code.
- ifun  in  4  current function code (carried for trace only; selection does not depend on it).
- rA  in  4  register specifier A from fetch; 4'hF = none.
- rB  in  4  register specifier B from fetch; 4'hF = none.
- valE  in  DATA_W  execute result.
- valM  in  DATA_W  memory read result.
- Cnd  in  1  condition result from execute; qualifies cmovXX.
- wb_en  in  1  writeback enable; when low, no register is written this edge.
- srcA  out  4  selected read index A.
- srcB  out  4  selected read index B.
- dstE  out  4  selected valE destination.
- dstM  out  4  selected valM destination.
- valA  out  DATA_W  contents of R[srcA]; 0 when srcA = 4'hF.
- valB  out  DATA_W  contents of R[srcB]; 0 when srcB = 4'hF.
- rsp_q  out  DATA_W  current %rsp, for stack debug.

Behaviour:
- Storage: 15 x DATA_W registers, indices 0..14; index 4'hF is "no register".
- Reset (async, rst=1): all registers clear to 0, except %rsp (see Optional Feature).
  - Outputs follow immediately: valA/valB/rsp_q show the reset contents.
  - Reset asserted mid-cycle discards any pending write.
- Selection is combinational from icode/rA/rB/Cnd:
  - srcA = rA for icode 2,4,6,A; 4 for icode 9,B; else F.
  - srcB = rB for icode 4,5,6; 4 for icode 8,9,A,B; else F.
  - dstE = rB for icode 3 and 6; rB for icode 2 only when Cnd=1 (F when Cnd=0); 4 for icode 8,9,A,B; else F.
  - dstM = rA for icode 5,B; else F.
  - icode 0, 1, 7 and any value greater than B select F for all four.
- Reads: combinational from current register state, zero latency. A write is visible on valA/valB starting the cycle after its clock edge. There is no same-cycle bypass, so no combinational loop through execute.
- Writes: on posedge clk with wb_en=1 and rst=0.
  - R[dstE] <= valE if dstE != F.
  - R[dstM] <= valM if dstM != F.
  - If dstE == dstM != F (popq %rsp), valM wins; exactly one write occurs.
  - Writes to index F are dropped.
  - wb_en=0 blocks both writes; state holds.
- rsp_q always equals R[4].

Optional Feature:
- Macro STACK_INIT_EN.
  - Defined: reset loads R[4] with STACK_BASE.
  - Undefined: R[4] resets to 0, like every other register.
- Selection, read and write behaviour are identical in both builds.

Test Plan:
- Reset: assert rst with clk held low -> valA/valB read 0 for every srcA/srcB. rsp_q = 0, or 64'h200 with STACK_INIT_EN.
- irmovq (icode 3, rB=2, valE=7) then rrmovq (icode 2, rA=2, rB=3, Cnd=1, valE=7):
  - dstE=2 first; next cycle srcA=2 and valA=7.
  - After the second edge, R[3]=7.
- cmovXX not taken (icode 2, ifun 1, rA=0, rB=5, Cnd=0, valE=9) -> dstE=F and R[5] unchanged after the edge. Repeat with Cnd=1 -> R[5]=9.
- popq %rsp (icode B, rA=4, valE=0x208, valM=0x55) -> dstE=dstM=4; after the edge R[4]=0x55 (M priority).
- pushq (icode A, rA=1) with R[4]=0x200 -> srcA=1, srcB=4, valB=0x200. Write valE=0x1F8 -> rsp_q=0x1F8 after the edge.
- wb_en=0 with OPq (icode 6, rB=6, valE=3) -> R[6] unchanged. Assert rst mid-cycle -> all registers clear asynchronously before the next edge.
